// File: rtl/uart_mmio_pkg.sv
// Shared constants and state encoding for the UART memory-mapped register front end.
package uart_mmio_pkg;

  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;

  localparam int unsigned STAT_RX_READY = 0;
  localparam int unsigned STAT_TX_READY = 1;
  localparam int unsigned STAT_RX_OVF   = 2;
  localparam int unsigned STAT_TX_DROP  = 3;

  localparam int unsigned CTRL_RX_IE = 0;
  localparam int unsigned CTRL_TX_IE = 1;

  localparam int unsigned RX_EMPTY_BIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    TX_WAIT,
    RESP
  } state_t;

  function automatic logic [31:0] status_word(input logic r_ready, input logic w_ready,
                                              input logic r_ovf, input logic tx_drop);
    logic [31:0] w;
    w                = '0;
    w[STAT_RX_READY] = r_ready;
    w[STAT_TX_READY] = w_ready;
    w[STAT_RX_OVF]   = r_ovf;
    w[STAT_TX_DROP]  = tx_drop;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio.sv
// CPU load/store register front end for the UART: DATA/STATUS/CTRL registers,
// single outstanding request, bounded stall on a full TX FIFO.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned TX_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  input  logic              uart_r_ready,
  input  logic              uart_r_overflow,
  input  logic [7:0]        uart_r_data,
  output logic              uart_r_enable,
  input  logic              uart_w_ready,
  output logic              uart_w_enable,
  output logic [7:0]        uart_w_data,
  output logic              irq
);

  localparam int unsigned CNT_W = (TX_TIMEOUT == 0) ? 1 : $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TX_TIMEOUT == 0) ? '0 : CNT_W'(TX_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_drop_q;
  logic [1:0]       ctrl_q;
  logic [31:0]      rdata_q;
  logic             push_q, pop_q;
  logic [7:0]       wbyte_q;
  logic             irq_q;

  logic [1:0] sel;
  logic       accept, is_data, is_status, is_ctrl;
  logic       tx_push_now, tx_timeout;
  logic       unused_bits;

  assign sel         = mem_addr[3:2];
  assign accept      = (state_q == IDLE) && mem_en;
  assign is_data     = (sel == DATA_OFF[3:2]);
  assign is_status   = (sel == STATUS_OFF[3:2]);
  assign is_ctrl     = (sel == CTRL_OFF[3:2]);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  assign mem_rdata   = rdata_q;
  assign uart_w_data = wbyte_q;
  assign irq         = irq_q;

  always_comb begin
    state_d       = state_q;
    tx_push_now   = 1'b0;
    tx_timeout    = 1'b0;
    mem_ready     = 1'b0;
    uart_r_enable = 1'b0;
    uart_w_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) state_d = (mem_we && is_data && !uart_w_ready) ? TX_WAIT : RESP;
      end
      TX_WAIT: begin
        // A push arriving on the final counted cycle takes priority over the drop.
        if (uart_w_ready) begin
          state_d     = RESP;
          tx_push_now = 1'b1;
        end else if ((TX_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d    = RESP;
          tx_timeout = 1'b1;
        end
      end
      RESP: begin
        state_d       = IDLE;
        mem_ready     = 1'b1;
        uart_r_enable = pop_q;
        uart_w_enable = push_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_drop_q <= 1'b0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      wbyte_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (ctrl_q[CTRL_RX_IE] & uart_r_ready) | (ctrl_q[CTRL_TX_IE] & uart_w_ready)
               | tx_drop_q;
      if (accept) begin
        rdata_q <= '0;
        cnt_q   <= '0;
        push_q  <= mem_we & is_data & uart_w_ready;
        pop_q   <= ~mem_we & is_data & uart_r_ready;
        if (mem_we && is_data) wbyte_q <= mem_wdata[7:0];
        if (!mem_we) begin
          if (is_data)
            rdata_q <= uart_r_ready ? {24'b0, uart_r_data} : (32'd1 << RX_EMPTY_BIT);
          else if (is_status)
            rdata_q <= status_word(uart_r_ready, uart_w_ready, uart_r_overflow, tx_drop_q);
          else if (is_ctrl)
            rdata_q <= {30'b0, ctrl_q};
        end else begin
          if (is_status && mem_wdata[STAT_TX_DROP]) tx_drop_q <= 1'b0;
          if (is_ctrl) ctrl_q <= {mem_wdata[CTRL_TX_IE], mem_wdata[CTRL_RX_IE]};
        end
      end
      if (tx_push_now) push_q <= 1'b1;
      if ((state_q == TX_WAIT) && (state_d == TX_WAIT) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      // Placed after the STATUS clear so a simultaneous set dominates.
      if (tx_timeout) tx_drop_q <= 1'b1;
    end
  end

endmodule
